mem_responder: RTL

- Single-ported scratchpad memory that serves as the responder on the core's memory request/response interface.
- Accepts one request at a time (read or write) with byte, halfword or word type. Returns a response after a fixed, parameterised latency.
- One instance serves instruction fetch; a second serves data.
- Drives the res_valid and read data that the control path consumes for cache-miss stall and writeback.

---
 rtl/mem_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Single-ported scratchpad memory acting as the responder on the core's
//   memory request/response interface. One request is in flight at a time;
//   the response pulse arrives a fixed LATENCY edges after acceptance.
//   Writes commit at the acceptance edge. Reads capture the addressed word at
//   the acceptance edge and present the extended result on the response pulse.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two)
//   LATENCY     : edges from acceptance to res_valid (1..7)
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted on this edge when req_valid is high
//   req_addr   in  32   byte address (wraps modulo 4*DEPTH_WORDS)
//   req_data   in  32   store data, right-aligned
//   req_fcn    in   1   0 = read, 1 = write
//   req_typ    in   3   access type (X/B/H/W/BU/HU/WU)
//   res_valid  out  1   one-cycle response pulse
//   res_data   out 32   extended load data; 0 for writes
//   res_err    out  1   misaligned-request flag (MEM_MISALIGN_TRAP_EN only)
//
// Build option
//   MEM_MISALIGN_TRAP_EN : flag misaligned H/HU/W/WU requests with res_err,
//                          suppress their write and return 0. When undefined,
//                          misaligned addresses are aligned down.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        res_valid,
    output logic [31:0] res_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        res_err
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;
    localparam logic [2:0] MT_WU = 3'd7;

    // Elaboration-time parameter sanity checks
    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..7");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_data;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic [AW-1:0]    idx;
    logic [1:0]       lane;
    logic             misalign;
    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;

    // Upper address bits fall outside the array and simply alias
    if (AW + 2 < 32) begin : g_addr_unused
        logic unused_addr;
        assign unused_addr = ^req_addr[31:AW+2];
    end

    // Request decode: handshake, word index and lane
    always_comb begin
        accept = req_valid && req_ready;
        idx    = req_addr[AW+1:2];
        lane   = req_addr[1:0];
    end

    // Misalignment detection; constant 0 unless trapping is built in
    always_comb begin
        misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        case (req_typ)
            MT_H, MT_HU: misalign = req_addr[0];
            MT_W, MT_WU: misalign = |req_addr[1:0];
            default:     misalign = 1'b0;
        endcase
`endif
    end

    // Store data replicated across lanes; the byte mask picks the live ones
    always_comb begin
        wmask = 4'b0000;
        wdata = req_data;
        case (req_typ)
            MT_B, MT_BU: begin
                wmask = 4'(4'b0001 << lane);
                wdata = {4{req_data[7:0]}};
            end
            MT_H, MT_HU: begin
                wmask = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req_data[15:0]}};
            end
            MT_W, MT_WU: begin
                wmask = 4'b1111;
                wdata = req_data;
            end
            default: begin
                wmask = 4'b0000;
            end
        endcase
        if (!req_fcn || misalign) begin
            wmask = 4'b0000;
        end
    end

    // Load path: select lane and extend per access type
    always_comb begin
        rd_word   = mem[idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'h0;
        case (req_typ)
            MT_B:        load_data = {{24{rd_byte[7]}}, rd_byte};
            MT_BU:       load_data = {24'h0, rd_byte};
            MT_H:        load_data = {{16{rd_half[15]}}, rd_half};
            MT_HU:       load_data = {16'h0, rd_half};
            MT_W, MT_WU: load_data = rd_word;
            MT_X:        load_data = 32'h0;
            default:     load_data = 32'h0;
        endcase
        if (req_fcn || misalign) begin
            load_data = 32'h0;
        end
    end

    // Storage array: not reset; writes blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (accept && reset) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic pend_err;
`endif

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_data <= 32'h0;
            req_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            pend_err  <= 1'b0;
            res_err   <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            res_err   <= 1'b0;
`endif
            case (state)
                // IDLE and RESP both accept; RESP acceptance gives back-to-back service
                IDLE, RESP: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            req_ready <= 1'b1;
                            res_valid <= 1'b1;
                            res_data  <= load_data;
`ifdef MEM_MISALIGN_TRAP_EN
                            res_err   <= misalign;
`endif
                        end else begin
                            state     <= WAIT;
                            req_ready <= 1'b0;
                            cnt       <= CNT_W'(LATENCY - 2);
                            pend_data <= load_data;
`ifdef MEM_MISALIGN_TRAP_EN
                            pend_err  <= misalign;
`endif
                        end
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                // Hold the captured result until the countdown expires
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                        res_valid <= 1'b1;
                        res_data  <= pend_data;
`ifdef MEM_MISALIGN_TRAP_EN
                        res_err   <= pend_err;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
